npu_instr_sequencer: RTL and testbench
======================================

// Module: npu_instr_sequencer
// PURPOSE
//  Instruction-memory controller feeding NPU. Host loads a program into an on-chip instruction RAM,
//  then pulses start; the block answers NPU get_instr/get_instr_addr fetches with a 1-cycle registered
//  instruction, detects END_CHAIN to finish, and guards the run with a fetch watchdog.
//  Sits beside NPU in the small bwave top, replacing the free-running instruction input.
// PARAMETERS
//  INSTR_WIDTH    48    instruction width; opcode = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH]
//  OPCODE_WIDTH   4     opcode field width
//  AWIDTH         10    instruction RAM address width (depth 2**AWIDTH)
//  END_OPCODE     12    END_CHAIN opcode value
//  WDOG_CYCLES    1024  max RUN cycles without a fetch before timeout (>=2)
// PORTS
//  clk            in   1            clock
//  rst            in   1            synchronous active-high reset
//  prog_wr_en     in   1            host program write strobe
//  prog_wr_addr   in   AWIDTH       host write address
//  prog_wr_data   in   INSTR_WIDTH  host write data
//  prog_len       in   AWIDTH+1     number of valid instructions; sampled on accepted start
//  start          in   1            begin run (accepted only in IDLE or DONE)
//  abort          in   1            force run to DONE
//  get_instr      in   1            NPU fetch request
//  get_instr_addr in   AWIDTH       NPU fetch address
//  instruction    out  INSTR_WIDTH  fetched instruction to NPU (registered)
//  instr_valid    out  1            1-cycle pulse: instruction updated this cycle
//  busy           out  1            high in RUN
//  done           out  1            high in DONE
//  status         out  3            {timeout, oob_fetch, wr_rejected}; sticky, cleared on accepted start
//  instr_count    out  AWIDTH+1     fetches served in current run (saturating)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched prog_len 0; RAM contents not reset.
//  States: IDLE -> RUN on start. RUN -> DONE on END_CHAIN served, watchdog expiry, or abort.
//   DONE -> RUN on start (new run, same RAM). DONE holds until start or rst.
//  Program writes: prog_wr_en in IDLE/DONE writes RAM[prog_wr_addr]. In RUN write ignored, wr_rejected set.
//  start & prog_wr_en same cycle (IDLE/DONE): write completes; first fetch next cycle reads new data.
//  Accepted start: latch prog_len, clear status, instr_count=0, watchdog=0, busy=1 next cycle.
//  start while RUN: ignored, no flag.
//  Fetch (RUN only): get_instr=1 in cycle N -> cycle N+1 instruction=RAM[get_instr_addr], instr_valid=1,
//   instr_count+1. Back-to-back fetches every cycle supported. get_instr outside RUN ignored.
//  Out-of-bounds: get_instr_addr >= latched prog_len -> return {END_OPCODE, zeros}, set oob_fetch,
//   finish as END_CHAIN.
//  END_CHAIN: when the served instruction's opcode == END_OPCODE, state=DONE in cycle N+1 together
//   with instr_valid (busy=0, done=1 that same cycle).
//  instruction holds last served value between fetches; never changes without instr_valid.
//  Watchdog: counts RUN cycles with get_instr=0, cleared by any fetch; reaching WDOG_CYCLES ->
//   timeout=1, DONE next cycle.
//  abort: highest priority over fetch/watchdog; in RUN -> DONE next cycle, pending fetch still served
//   (instr_valid pulses) but no further fetches accepted. abort in IDLE/DONE: no effect.
//  Same-cycle abort+start in RUN: abort wins. rst mid-RUN: immediate IDLE, outputs 0, RAM kept.
//  instr_count saturates at 2**(AWIDTH+1)-1.
// TESTING
//  Load 3 instr (opcodes 2,4,12) addr0-2, prog_len=3, start; fetch 0,1,2 back-to-back -> instr_valid
//   3 cycles, each 1 cycle after request; done=1 with 3rd; instr_count=3; status=0.
//  Run, fetch addr 5 with prog_len=3 -> instruction opcode 12 rest 0, status=3'b010, done=1.
//  Run, stall get_instr WDOG_CYCLES cycles -> status=3'b100, done=1, busy=0 next cycle.
//  prog_wr_en during RUN to addr0 -> RAM unchanged (rerun reads old value), status[0]=1.
//  abort same cycle as fetch addr1 -> instr_valid once with RAM[1], done=1, later get_instr ignored.
//  rst mid-RUN then start without reload -> program runs again from retained RAM, status=0.

Source files
------------

// File: rtl/npu_instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : npu_instr_sequencer_if
// Brief    : Host program-load, run-control and NPU fetch signals of the
//            instruction sequencer, with host/NPU (master) and sequencer
//            (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
interface npu_instr_sequencer_if #(
    parameter int INSTR_WIDTH = 48,
    parameter int AWIDTH      = 10
);
    logic                   prog_wr_en;
    logic [AWIDTH-1:0]      prog_wr_addr;
    logic [INSTR_WIDTH-1:0] prog_wr_data;
    logic [AWIDTH:0]        prog_len;
    logic                   start;
    logic                   abort;
    logic                   get_instr;
    logic [AWIDTH-1:0]      get_instr_addr;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic                   busy;
    logic                   done;
    logic [2:0]             status;
    logic [AWIDTH:0]        instr_count;

    modport master (
        output prog_wr_en, prog_wr_addr, prog_wr_data, prog_len,
        output start, abort, get_instr, get_instr_addr,
        input  instruction, instr_valid, busy, done, status, instr_count
    );

    modport slave (
        input  prog_wr_en, prog_wr_addr, prog_wr_data, prog_len,
        input  start, abort, get_instr, get_instr_addr,
        output instruction, instr_valid, busy, done, status, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/npu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : npu_instr_sequencer
// Brief    : Instruction RAM controller for the NPU: host program load, run
//            control, registered fetch, END_CHAIN detection and watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module npu_instr_sequencer #(
    parameter int INSTR_WIDTH  = 48,
    parameter int OPCODE_WIDTH = 4,
    parameter int AWIDTH       = 10,
    parameter int END_OPCODE   = 12,
    parameter int WDOG_CYCLES  = 1024
) (
    input  wire logic            clk,
    input  wire logic            rst,
    npu_instr_sequencer_if.slave bus
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [OPCODE_WIDTH-1:0] c_end_op = OPCODE_WIDTH'(END_OPCODE);
    localparam logic [INSTR_WIDTH-1:0]  c_end_instr =
        {c_end_op, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};
    localparam logic [AWIDTH:0]         c_count_max = '1;
    localparam logic [WDOG_W-1:0]       c_wdog_last = WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [INSTR_WIDTH-1:0] r_mem [0:(2**AWIDTH)-1];
    logic [INSTR_WIDTH-1:0] r_instruction;
    logic                   r_instr_valid;
    logic [2:0]             r_status;
    logic [AWIDTH:0]        r_instr_count;
    logic [AWIDTH:0]        r_prog_len;
    logic [WDOG_W-1:0]      r_wdog;

    logic                   w_run;
    logic                   w_start_ok;
    logic                   w_fetch;
    logic                   w_oob;
    logic [INSTR_WIDTH-1:0] w_rd_data;
    logic                   w_end_hit;
    logic                   w_wdog_expire;

    assign w_run         = (r_state == ST_RUN);
    assign w_start_ok    = bus.start && !w_run;
    assign w_fetch       = w_run && bus.get_instr;
    assign w_oob         = ({1'b0, bus.get_instr_addr} >= r_prog_len);
    // Out-of-range fetches are answered with a synthetic END_CHAIN so the NPU stops cleanly.
    assign w_rd_data     = w_oob ? c_end_instr : r_mem[bus.get_instr_addr];
    assign w_end_hit     = w_fetch && (w_rd_data[INSTR_WIDTH-1 -: OPCODE_WIDTH] == c_end_op);
    assign w_wdog_expire = w_run && !bus.get_instr && (r_wdog == c_wdog_last);

    always_ff @(posedge clk) begin
        if (bus.prog_wr_en && !w_run) begin
            r_mem[bus.prog_wr_addr] <= bus.prog_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_next = ST_RUN;
            ST_RUN:  if (bus.abort || w_end_hit || w_wdog_expire) w_state_next = ST_DONE;
            ST_DONE: if (bus.start) w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
            r_status      <= 3'b000;
            r_instr_count <= '0;
            r_prog_len    <= '0;
            r_wdog        <= '0;
        end else begin
            r_instr_valid <= w_fetch;
            if (w_fetch) begin
                r_instruction <= w_rd_data;
            end
            if (w_start_ok) begin
                r_prog_len    <= bus.prog_len;
                r_status      <= 3'b000;
                r_instr_count <= '0;
                r_wdog        <= '0;
            end else if (w_run) begin
                r_wdog <= bus.get_instr ? '0 : r_wdog + 1'b1;
                if (w_fetch && (r_instr_count != c_count_max)) begin
                    r_instr_count <= r_instr_count + 1'b1;
                end
                if (bus.prog_wr_en) begin
                    r_status[0] <= 1'b1;
                end
                if (w_fetch && w_oob) begin
                    r_status[1] <= 1'b1;
                end
                // An abort in the same cycle ends the run as an abort, not a timeout.
                if (w_wdog_expire && !bus.abort) begin
                    r_status[2] <= 1'b1;
                end
            end
        end
    end

    assign bus.instruction = r_instruction;
    assign bus.instr_valid = r_instr_valid;
    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.status      = r_status;
    assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_npu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_instr_sequencer
// Brief    : Directed self-checking bench for npu_instr_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_instr_sequencer;

    localparam int IW = 48;
    localparam int OW = 4;
    localparam int AW = 10;
    localparam int EO = 12;
    localparam int WD = 1024;

    localparam logic [IW-1:0] c_i0    = {4'd2,  44'h000_0000_0111};
    localparam logic [IW-1:0] c_i1    = {4'd4,  44'h000_0000_0222};
    localparam logic [IW-1:0] c_i2    = {4'd12, 44'h000_0000_0333};
    localparam logic [IW-1:0] c_other = {4'd7,  44'h0AB_CDEF_0123};
    localparam logic [IW-1:0] c_endz  = {4'd12, 44'h0};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    npu_instr_sequencer_if #(.INSTR_WIDTH(IW), .AWIDTH(AW)) bus ();

    npu_instr_sequencer #(
        .INSTR_WIDTH (IW),
        .OPCODE_WIDTH(OW),
        .AWIDTH      (AW),
        .END_OPCODE  (EO),
        .WDOG_CYCLES (WD)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [IW-1:0] data);
        bus.prog_wr_en   = 1'b1;
        bus.prog_wr_addr = addr;
        bus.prog_wr_data = data;
        tick();
        bus.prog_wr_en   = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] addr);
        bus.get_instr      = 1'b1;
        bus.get_instr_addr = addr;
        tick();
        bus.get_instr      = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.prog_wr_en     = 1'b0;
        bus.prog_wr_addr   = '0;
        bus.prog_wr_data   = '0;
        bus.prog_len       = 11'd3;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.get_instr      = 1'b0;
        bus.get_instr_addr = '0;
        tick();
        tick();
        check_eq("rst_instr",  64'(bus.instruction), 64'h0);
        check_eq("rst_valid",  64'(bus.instr_valid), 64'h0);
        check_eq("rst_busy",   64'(bus.busy),        64'h0);
        check_eq("rst_done",   64'(bus.done),        64'h0);
        check_eq("rst_status", 64'(bus.status),      64'h0);
        check_eq("rst_count",  64'(bus.instr_count), 64'h0);
        rst = 1'b0;

        // Load program; last write shares its cycle with start.
        write_word(10'd0, c_i0);
        write_word(10'd1, c_i1);
        bus.start = 1'b1;
        write_word(10'd2, c_i2);
        bus.start = 1'b0;
        check_eq("start_busy",  64'(bus.busy),        64'h1);
        check_eq("start_count", 64'(bus.instr_count), 64'h0);

        // Back-to-back fetches of the three-instruction program.
        bus.get_instr = 1'b1;
        bus.get_instr_addr = 10'd0;
        tick();
        check_eq("f0_valid", 64'(bus.instr_valid), 64'h1);
        check_eq("f0_instr", 64'(bus.instruction), 64'(c_i0));
        check_eq("f0_busy",  64'(bus.busy),        64'h1);
        bus.get_instr_addr = 10'd1;
        tick();
        check_eq("f1_valid", 64'(bus.instr_valid), 64'h1);
        check_eq("f1_instr", 64'(bus.instruction), 64'(c_i1));
        bus.get_instr_addr = 10'd2;
        tick();
        bus.get_instr = 1'b0;
        check_eq("f2_valid",  64'(bus.instr_valid), 64'h1);
        check_eq("f2_instr",  64'(bus.instruction), 64'(c_i2));
        check_eq("f2_done",   64'(bus.done),        64'h1);
        check_eq("f2_busy",   64'(bus.busy),        64'h0);
        check_eq("f2_count",  64'(bus.instr_count), 64'h3);
        check_eq("f2_status", 64'(bus.status),      64'h0);
        tick();
        check_eq("hold_valid", 64'(bus.instr_valid), 64'h0);
        check_eq("hold_instr", 64'(bus.instruction), 64'(c_i2));

        // Out-of-bounds fetch.
        do_start();
        fetch(10'd5);
        check_eq("oob_instr",  64'(bus.instruction), 64'(c_endz));
        check_eq("oob_status", 64'(bus.status),      64'h2);
        check_eq("oob_done",   64'(bus.done),        64'h1);
        check_eq("oob_count",  64'(bus.instr_count), 64'h1);

        // Host write during RUN is rejected.
        do_start();
        check_eq("rerun_status", 64'(bus.status), 64'h0);
        write_word(10'd0, c_other);
        check_eq("wrrej_status", 64'(bus.status), 64'h1);
        check_eq("wrrej_busy",   64'(bus.busy),   64'h1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("abort_done",   64'(bus.done),   64'h1);
        check_eq("abort_status", 64'(bus.status), 64'h1);

        // Rerun reads the original word; then abort alongside a fetch.
        do_start();
        check_eq("clr_status", 64'(bus.status), 64'h0);
        fetch(10'd0);
        check_eq("kept_instr", 64'(bus.instruction), 64'(c_i0));
        bus.abort = 1'b1;
        fetch(10'd1);
        bus.abort = 1'b0;
        check_eq("abf_valid", 64'(bus.instr_valid), 64'h1);
        check_eq("abf_instr", 64'(bus.instruction), 64'(c_i1));
        check_eq("abf_done",  64'(bus.done),        64'h1);
        check_eq("abf_busy",  64'(bus.busy),        64'h0);
        fetch(10'd2);
        check_eq("post_valid", 64'(bus.instr_valid), 64'h0);
        check_eq("post_instr", 64'(bus.instruction), 64'(c_i1));
        check_eq("post_count", 64'(bus.instr_count), 64'h2);

        // Watchdog boundary: still running one cycle short of the limit.
        do_start();
        repeat (WD - 1) tick();
        check_eq("wd_pre_busy",   64'(bus.busy),   64'h1);
        check_eq("wd_pre_status", 64'(bus.status), 64'h0);
        tick();
        check_eq("wd_done",   64'(bus.done),   64'h1);
        check_eq("wd_busy",   64'(bus.busy),   64'h0);
        check_eq("wd_status", 64'(bus.status), 64'h4);

        // Reset mid-run, then rerun from retained RAM.
        do_start();
        fetch(10'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_busy",  64'(bus.busy),        64'h0);
        check_eq("mrst_instr", 64'(bus.instruction), 64'h0);
        check_eq("mrst_count", 64'(bus.instr_count), 64'h0);
        do_start();
        check_eq("mrst_run", 64'(bus.busy), 64'h1);
        fetch(10'd0);
        check_eq("mr0_instr", 64'(bus.instruction), 64'(c_i0));
        fetch(10'd1);
        check_eq("mr1_instr", 64'(bus.instruction), 64'(c_i1));
        fetch(10'd2);
        check_eq("mr2_instr",  64'(bus.instruction), 64'(c_i2));
        check_eq("mr2_done",   64'(bus.done),        64'h1);
        check_eq("mr2_status", 64'(bus.status),      64'h0);
        check_eq("mr2_count",  64'(bus.instr_count), 64'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
